iob_aclint: RTL and testbench



---
 rtl/iob_aclint.sv | 205 ++++++++++++++++++++
 tb/tb_iob_aclint.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/iob_aclint.sv
// iob_aclint: ACLINT-style interrupt block (MSWI, MTIMER, optional SSWI) for up
// to 32 harts on the IOb native bus. mtime ticks on a synchronised rt_clk
// rising edge or on an internal clk prescaler, and FREEZE can stop it.
// Defining IOB_ACLINT_SSWI_EN adds the SSWI device at 0xC000 and the ssip port.
//
// Bus handshake: the block never stalls. ready is valid delayed by one cycle.
// A request is a write when valid & |wstrb, and a read otherwise. rdata carries
// the register value from the cycle valid was sampled, so a read-with-write
// returns the old value. Only the byte lanes whose wstrb bit is set are written.
module iob_aclint #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int N_CORES     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rt_clk,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic [N_CORES-1:0]    mtip,
  output logic [N_CORES-1:0]    msip
`ifdef IOB_ACLINT_SSWI_EN
  ,
  output logic [N_CORES-1:0]    ssip
`endif
);

  localparam int WA_W = ADDR_W - 2;
  localparam logic [WA_W-1:0] CMP_BASE  = WA_W'(32'h1000);  // byte 0x4000
  localparam logic [WA_W-1:0] CTRL_WA   = WA_W'(32'h2FFC);  // byte 0xBFF0
  localparam logic [WA_W-1:0] MTL_WA    = WA_W'(32'h2FFE);  // byte 0xBFF8
  localparam logic [WA_W-1:0] MTH_WA    = WA_W'(32'h2FFF);  // byte 0xBFFC
  localparam logic [WA_W-1:0] NC        = WA_W'(N_CORES);

  // Replace the byte lanes of old_v selected by strb with those of new_v.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  logic [WA_W-1:0] waddr;
  logic [WA_W-1:0] off_cmp;
  logic            wr;
  logic            sel_msip, sel_cmp, sel_ctrl, sel_mtl, sel_mth;
  logic [4:0]      msip_hart, cmp_hart;
  logic            cmp_hi;
  logic [31:0]     rd_val;
  logic [31:0]     ctrl_rd, ctrl_new;

  logic [63:0]             mtime;
  logic [63:0]             mtimecmp [N_CORES];
  logic [N_CORES-1:0]      msip_r;
  logic                    tick_src, freeze;
  logic [7:0]              prescale, presc_cnt;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rt_prev;
  logic                    tick;

  logic unused_bits;
  assign unused_bits = ^{address[1:0], ctrl_new[31:16], ctrl_new[7:2]};

  assign waddr     = address[ADDR_W-1:2];
  assign off_cmp   = waddr - CMP_BASE;
  assign wr        = valid & (|wstrb);
  assign sel_msip  = waddr < NC;
  assign sel_cmp   = (waddr >= CMP_BASE) && (off_cmp < (NC << 1));
  assign sel_ctrl  = waddr == CTRL_WA;
  assign sel_mtl   = waddr == MTL_WA;
  assign sel_mth   = waddr == MTH_WA;
  assign msip_hart = waddr[4:0];
  assign cmp_hart  = off_cmp[5:1];
  assign cmp_hi    = off_cmp[0];
  assign ctrl_rd   = {16'b0, prescale, 6'b0, freeze, tick_src};
  assign ctrl_new  = merge_bytes(ctrl_rd, wdata, wstrb);
  assign msip      = msip_r;

`ifdef IOB_ACLINT_SSWI_EN
  localparam logic [WA_W-1:0] SSWI_BASE = WA_W'(32'h3000);  // byte 0xC000
  logic [WA_W-1:0]    off_sswi;
  logic               sel_sswi;
  logic [4:0]         sswi_hart;
  logic [N_CORES-1:0] ssip_r;
  assign off_sswi  = waddr - SSWI_BASE;
  assign sel_sswi  = (waddr >= SSWI_BASE) && (off_sswi < NC);
  assign sswi_hart = off_sswi[4:0];
  assign ssip      = ssip_r;

  // SSWI pending bits: wdata[0] sets, wdata[1] clears, set has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssip_r <= '0;
    end else if (wr && sel_sswi && wstrb[0]) begin
      for (int h = 0; h < N_CORES; h++) begin
        if (sswi_hart == 5'(h)) begin
          if (wdata[0])      ssip_r[h] <= 1'b1;
          else if (wdata[1]) ssip_r[h] <= 1'b0;
        end
      end
    end
  end
`endif

  // Read mux: value of the addressed register before any write this cycle.
  always_comb begin
    rd_val = '0;
    for (int h = 0; h < N_CORES; h++) begin
      if (sel_msip && msip_hart == 5'(h)) rd_val = {31'b0, msip_r[h]};
      if (sel_cmp && cmp_hart == 5'(h))
        rd_val = cmp_hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
`ifdef IOB_ACLINT_SSWI_EN
      if (sel_sswi && sswi_hart == 5'(h)) rd_val = {31'b0, ssip_r[h]};
`endif
    end
    if (sel_ctrl) rd_val = ctrl_rd;
    if (sel_mtl)  rd_val = mtime[31:0];
    if (sel_mth)  rd_val = mtime[63:32];
  end

  // Bus response: acknowledge every request one cycle later with its read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid;
      rdata <= valid ? rd_val : '0;
    end
  end

  // Software-writable registers: MSIP bits, mtimecmp words and CTRL fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_r   <= '0;
      tick_src <= 1'b0;
      freeze   <= 1'b0;
      prescale <= 8'd0;
      for (int h = 0; h < N_CORES; h++) mtimecmp[h] <= '1;
    end else if (wr) begin
      for (int h = 0; h < N_CORES; h++) begin
        if (sel_msip && msip_hart == 5'(h) && wstrb[0]) msip_r[h] <= wdata[0];
        if (sel_cmp && cmp_hart == 5'(h)) begin
          if (cmp_hi)
            mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], wdata, wstrb);
          else
            mtimecmp[h][31:0]  <= merge_bytes(mtimecmp[h][31:0], wdata, wstrb);
        end
      end
      if (sel_ctrl) begin
        tick_src <= ctrl_new[0];
        freeze   <= ctrl_new[1];
        prescale <= ctrl_new[15:8];
      end
    end
  end

  // rt_clk synchroniser plus previous-value register for rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      rt_prev <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rt_clk};
      rt_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // Prescale down-counter: reloads at zero and on any CTRL write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  presc_cnt <= 8'd0;
    else if (wr && sel_ctrl)  presc_cnt <= ctrl_new[15:8];
    else if (presc_cnt == 0)  presc_cnt <= prescale;
    else                      presc_cnt <= presc_cnt - 8'd1;
  end

  assign tick = ~freeze & (tick_src ? (presc_cnt == 8'd0)
                                    : (sync_q[SYNC_STAGES-1] & ~rt_prev));

  // mtime: a bus write to either word wins and drops that cycle's tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 mtime <= '0;
    else if (wr && sel_mtl)  mtime[31:0]  <= merge_bytes(mtime[31:0], wdata, wstrb);
    else if (wr && sel_mth)  mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wstrb);
    else if (tick)           mtime <= mtime + 64'd1;
  end

  // Timer interrupts: registered unsigned compare of current mtime vs mtimecmp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtip <= '0;
    end else begin
      for (int h = 0; h < N_CORES; h++) mtip[h] <= (mtime >= mtimecmp[h]);
    end
  end

endmodule

// File: tb/tb_iob_aclint.sv
// tb_iob_aclint: directed bench for iob_aclint with two harts. A vector table
// covers register access, strobes and address decode; hand-written sequences
// cover tick latency, prescaler, freeze, mtip timing and mtime wrap/collision.
`timescale 1ns/1ps
module tb_iob_aclint;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rt_clk = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [1:0]  mtip;
  logic [1:0]  msip;
`ifdef IOB_ACLINT_SSWI_EN
  logic [1:0]  ssip;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_msip;
  } vec_t;

  vec_t vecs[$];

  iob_aclint #(.ADDR_W(16), .DATA_W(32), .N_CORES(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rt_clk(rt_clk), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .mtip(mtip), .msip(msip)
`ifdef IOB_ACLINT_SSWI_EN
    , .ssip(ssip)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks: called at a negedge, return at the following negedge.
  task automatic bus_xfer(input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    @(negedge clk);
    rd = rdata;
    check("ready", {63'b0, ready}, 64'd1);
    valid = 1'b0; wstrb = '0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    bus_xfer(a, d, s, rd);
  endtask

  task automatic bus_rd_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(a, 32'h0, 4'h0, rd);
    check(name, {32'b0, rd}, {32'b0, exp});
  endtask

  task automatic add(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] er, input logic [1:0] em);
    vec_t v;
    v.addr = a; v.wdata = d; v.wstrb = s; v.exp_rdata = er; v.exp_msip = em;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;

    // Reset block.
    repeat (3) @(negedge clk);
    check("rst_mtip",  {62'b0, mtip},  64'd0);
    check("rst_msip",  {62'b0, msip},  64'd0);
    check("rst_ready", {63'b0, ready}, 64'd0);
    check("rst_rdata", {32'b0, rdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table: addr, wdata, wstrb, expected rdata, expected msip after.
    add(16'h4000, 32'h0,        4'h0, 32'hFFFF_FFFF, 2'b00);
    add(16'h4004, 32'h0,        4'h0, 32'hFFFF_FFFF, 2'b00);
    add(16'h400C, 32'h0,        4'h0, 32'hFFFF_FFFF, 2'b00);
    add(16'hBFF8, 32'h0,        4'h0, 32'h0,         2'b00);
    add(16'hBFFC, 32'h0,        4'h0, 32'h0,         2'b00);
    add(16'hBFF0, 32'h0,        4'h0, 32'h0,         2'b00);
    add(16'h0004, 32'h1,        4'h0, 32'h0,         2'b00);
    add(16'h0004, 32'h1,        4'h1, 32'h0,         2'b10);
    add(16'h0004, 32'h0,        4'h0, 32'h1,         2'b10);
    add(16'h0008, 32'h0,        4'h0, 32'h0,         2'b10);
    add(16'h0008, 32'hFFFF_FFFF, 4'hF, 32'h0,        2'b10);
    add(16'h0008, 32'h0,        4'h0, 32'h0,         2'b10);
    add(16'h0000, 32'hFFFF_FFFF, 4'hF, 32'h0,        2'b11);
    add(16'h0000, 32'h0,        4'h0, 32'h1,         2'b11);
    add(16'h0004, 32'h0,        4'hF, 32'h1,         2'b01);
    add(16'h4008, 32'hA5A5_A5A5, 4'h3, 32'hFFFF_FFFF, 2'b01);
    add(16'h4008, 32'h0,        4'h0, 32'hFFFF_A5A5, 2'b01);
    add(16'h4010, 32'h0,        4'h0, 32'h0,         2'b01);
    add(16'h4010, 32'h0,        4'hF, 32'h0,         2'b01);
    add(16'h4000, 32'h0,        4'h0, 32'hFFFF_FFFF, 2'b01);
    add(16'h8000, 32'h0,        4'h0, 32'h0,         2'b01);
`ifndef IOB_ACLINT_SSWI_EN
    add(16'hC000, 32'h1,        4'hF, 32'h0,         2'b01);
    add(16'hC000, 32'h0,        4'h0, 32'h0,         2'b01);
`endif
    add(16'hBFF0, 32'hFFFF_FFFF, 4'hF, 32'h0,        2'b01);
    add(16'hBFF0, 32'h0,        4'h0, 32'h0000_FF03, 2'b01);
    add(16'hBFF0, 32'h0,        4'hF, 32'h0000_FF03, 2'b01);
    add(16'hBFF0, 32'h0,        4'h0, 32'h0,         2'b01);
    add(16'h0000, 32'h0,        4'h1, 32'h1,         2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      bus_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd);
      check($sformatf("vec%0d_rdata", i), {32'b0, rd}, {32'b0, vecs[i].exp_rdata});
      check($sformatf("vec%0d_msip", i), {62'b0, msip}, {62'b0, vecs[i].exp_msip});
      check($sformatf("vec%0d_mtip", i), {62'b0, mtip}, 64'd0);
    end

    // rt_clk tick source: exact first-tick latency, then 10 edges total.
    rt_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_rd_chk("rt_before_tick", 16'hBFF8, 32'd0);
    bus_rd_chk("rt_after_tick",  16'hBFF8, 32'd1);
    repeat (4) @(negedge clk);
    rt_clk = 1'b0;
    repeat (8) @(negedge clk);
    for (int e = 0; e < 9; e++) begin
      rt_clk = 1'b1;
      repeat (8) @(negedge clk);
      rt_clk = 1'b0;
      repeat (8) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    bus_rd_chk("rt_10_edges", 16'hBFF8, 32'd10);
    bus_rd_chk("rt_high_word", 16'hBFFC, 32'd0);

    // Prescaler 3: one tick every 4 clk, first one 4 clk after the CTRL write.
    bus_wr(16'hBFF0, 32'h0000_0301, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      bus_rd_chk($sformatf("presc_k%0d", k), 16'hBFF8, 32'd10 + 32'((k - 1) / 4));
    end
    bus_wr(16'hBFF0, 32'h0000_0303, 4'hF);
    repeat (20) @(negedge clk);
    bus_rd_chk("freeze_hold", 16'hBFF8, 32'd12);
    bus_wr(16'hBFF0, 32'h0000_0301, 4'hF);
    repeat (19) @(negedge clk);
    bus_rd_chk("freeze_resume", 16'hBFF8, 32'd16);
    bus_wr(16'hBFF0, 32'h0, 4'hF);

    // mtip timing with a tick every cycle.
    bus_wr(16'hBFF8, 32'h0, 4'hF);
    bus_wr(16'hBFFC, 32'h0, 4'hF);
    bus_wr(16'h4000, 32'd5, 4'hF);
    bus_wr(16'h4004, 32'd0, 4'hF);
    check("mtip_idle", {62'b0, mtip}, 64'd0);
    bus_wr(16'hBFF0, 32'h0000_0001, 4'hF);
    repeat (5) @(negedge clk);
    check("mtip_at_5", {62'b0, mtip}, 64'd0);
    @(negedge clk);
    check("mtip_rise", {62'b0, mtip}, 64'd1);
    bus_wr(16'h4004, 32'd1, 4'hF);
    check("mtip_hold", {62'b0, mtip}, 64'd1);
    @(negedge clk);
    check("mtip_fall", {62'b0, mtip}, 64'd0);
    bus_wr(16'hBFF0, 32'h0, 4'hF);

    // mtime wrap on a single rt_clk tick.
    bus_wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    bus_wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    bus_rd_chk("wrap_pre_hi", 16'hBFFC, 32'hFFFF_FFFF);
    rt_clk = 1'b1;
    repeat (5) @(negedge clk);
    rt_clk = 1'b0;
    bus_rd_chk("wrap_lo", 16'hBFF8, 32'd0);
    bus_rd_chk("wrap_hi", 16'hBFFC, 32'd0);

    // Write colliding with a tick: written value kept, tick dropped.
    bus_wr(16'hBFFC, 32'd7, 4'hF);
    bus_wr(16'hBFF8, 32'h100, 4'hF);
    bus_wr(16'hBFF0, 32'h0000_0001, 4'hF);
    bus_wr(16'hBFF8, 32'h1234, 4'hF);
    bus_rd_chk("collide_lo", 16'hBFF8, 32'h1234);
    bus_rd_chk("collide_hi", 16'hBFFC, 32'd7);
    bus_wr(16'hBFF0, 32'h0, 4'hF);

    // Single byte-lane write into the high word.
    bus_wr(16'hBFFC, 32'h00AB_0000, 4'b0100);
    bus_rd_chk("strobe_hi", 16'hBFFC, 32'h00AB_0007);

`ifdef IOB_ACLINT_SSWI_EN
    bus_wr(16'hC004, 32'h1, 4'h1);
    check("ssip_set", {62'b0, ssip}, 64'd2);
    bus_wr(16'hC004, 32'h3, 4'h1);
    check("ssip_both", {62'b0, ssip}, 64'd2);
    bus_rd_chk("ssip_rd", 16'hC004, 32'd1);
    bus_wr(16'hC004, 32'h2, 4'h1);
    check("ssip_clr", {62'b0, ssip}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
